// File: rtl/frq_div_prog_pkg.sv
// frq_div_prog_pkg: mode encodings, 50 MHz board default ratios and the ratio-to-limit helper
package frq_div_prog_pkg;
  typedef enum logic [1:0] {FRQ_MODE_0, FRQ_MODE_1, FRQ_MODE_2, FRQ_MODE_3} frq_mode_e;
  localparam int unsigned DEF_DIV0 = 10;
  localparam int unsigned DEF_DIV1 = 100;
  localparam int unsigned DEF_DIV2 = 1000;
  localparam int unsigned DEF_DIV3 = 50000000;
  localparam int unsigned DEF_SUB_DIV = 10;
  function automatic int unsigned div_lim(input int unsigned div);
    return (div == 0) ? 0 : div - 1;
  endfunction
endpackage

// File: rtl/frq_mod_cnt.sv
// frq_mod_cnt: modulo counter 0..lim; in mclk/rst/en/sclr/lim, out wrap (en-qualified terminal pulse)
module frq_mod_cnt
  import frq_div_prog_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         en,
  input  logic         sclr,
  input  logic [W-1:0] lim,
  output logic         wrap
);
  logic [W-1:0] cnt;
  assign wrap = en && !sclr && cnt == lim;
  always_ff @(posedge mclk or posedge rst)
    if (rst) cnt <= '0;
    else if (sclr) cnt <= '0;
    else if (en) cnt <= (cnt == lim) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/frq_div_prog.sv
// frq_div_prog: runtime-selectable mclk divider; in rst/en/sclr/mode, out tick/clk_sq/sub_tick/mode_act
module frq_div_prog
  import frq_div_prog_pkg::*;
#(
  parameter int          CNT_W   = 27,
  parameter int unsigned DIV0    = DEF_DIV0,
  parameter int unsigned DIV1    = DEF_DIV1,
  parameter int unsigned DIV2    = DEF_DIV2,
  parameter int unsigned DIV3    = DEF_DIV3,
  parameter int unsigned SUB_DIV = DEF_SUB_DIV
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       en,
  input  logic       sclr,
  input  logic [1:0] mode,
  output logic       tick,
  output logic       clk_sq,
  output logic       sub_tick,
  output logic [1:0] mode_act
);
  localparam int SUB_W = $clog2(SUB_DIV + 1);
  logic [CNT_W-1:0] lim;
  logic wrap, sub_wrap;
  always_comb
    lim = mode_act == FRQ_MODE_0 ? CNT_W'(div_lim(DIV0)) :
          mode_act == FRQ_MODE_1 ? CNT_W'(div_lim(DIV1)) :
          mode_act == FRQ_MODE_2 ? CNT_W'(div_lim(DIV2)) : CNT_W'(div_lim(DIV3));
  frq_mod_cnt #(.W(CNT_W)) u_main (
    .mclk(mclk), .rst(rst), .en(en), .sclr(sclr), .lim(lim), .wrap(wrap)
  );
  // sub stage advances only on main terminal cycles, so its wrap coincides with a tick
  frq_mod_cnt #(.W(SUB_W)) u_sub (
    .mclk(mclk), .rst(rst), .en(wrap), .sclr(sclr), .lim(SUB_W'(SUB_DIV - 1)), .wrap(sub_wrap)
  );
  // mode_act only changes at a terminal count (cnt wraps to 0) or on sclr, so cnt never exceeds lim
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      tick <= 1'b0;
      sub_tick <= 1'b0;
      clk_sq <= 1'b0;
      mode_act <= FRQ_MODE_0;
    end else begin
      tick <= wrap;
      sub_tick <= sub_wrap;
      clk_sq <= sclr ? 1'b0 : clk_sq ^ wrap;
      mode_act <= (sclr || wrap) ? mode : mode_act;
    end
endmodule

// File: tb/tb_frq_div_prog.sv
// tb_frq_div_prog: directed checks of frq_div_prog with DIV0..3=3,5,1,8 and SUB_DIV=4
module tb_frq_div_prog;
  logic mclk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic sclr = 1'b0;
  logic [1:0] mode = 2'd0;
  logic tick, clk_sq, sub_tick;
  logic [1:0] mode_act;
  int total = 0;
  int bad = 0;
  frq_div_prog #(.DIV0(3), .DIV1(5), .DIV2(1), .DIV3(8), .SUB_DIV(4)) dut (
    .mclk(mclk), .rst(rst), .en(en), .sclr(sclr), .mode(mode),
    .tick(tick), .clk_sq(clk_sq), .sub_tick(sub_tick), .mode_act(mode_act)
  );
  always #5 mclk = ~mclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge mclk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    do_reset();
    chk("rst_tick", tick, 0);
    chk("rst_sq", clk_sq, 0);
    chk("rst_sub", sub_tick, 0);
    chk("rst_mode", mode_act, 0);
    en = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      chk("t1_tick", tick, c % 3 == 0);
      chk("t1_sub", sub_tick, c == 12 || c == 24);
      chk("t1_sq", clk_sq, (c / 3) % 2);
    end
    do_reset();
    mode = 2'd0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 4) mode = 2'd1;
      chk("t2_tick", tick, c == 3 || c == 6 || c == 11 || c == 16);
      chk("t2_mode", mode_act, c >= 6);
    end
    do_reset();
    mode = 2'd2;
    sclr = 1'b1;
    step();
    chk("t3_clr_mode", mode_act, 2);
    chk("t3_clr_tick", tick, 0);
    chk("t3_clr_sq", clk_sq, 0);
    sclr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t3_div1_tick", tick, 1);
      chk("t3_div1_sq", clk_sq, c % 2);
    end
    mode = 2'd3;
    for (int c = 5; c <= 13; c++) begin
      step();
      chk("t3_tick", tick, c == 5 || c == 13);
      chk("t3_sq", clk_sq, c >= 5 && c < 13);
      chk("t3_mode", mode_act, 3);
    end
    do_reset();
    mode = 2'd0;
    step();
    en = 1'b0;
    mode = 2'd1;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("t4_frz_tick", tick, 0);
      chk("t4_frz_sq", clk_sq, 0);
      chk("t4_frz_mode", mode_act, 0);
    end
    en = 1'b1;
    step();
    chk("t4_res1_tick", tick, 0);
    step();
    chk("t4_res2_tick", tick, 1);
    chk("t4_res2_mode", mode_act, 1);
    chk("t4_res2_sq", clk_sq, 1);
    do_reset();
    mode = 2'd0;
    step();
    step();
    mode = 2'd3;
    sclr = 1'b1;
    step();
    chk("t5_clr_tick", tick, 0);
    chk("t5_clr_sq", clk_sq, 0);
    chk("t5_clr_mode", mode_act, 3);
    sclr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("t5_tick", tick, c == 8);
    end
    chk("t5_sq", clk_sq, 1);
    step();
    step();
    en = 1'b0;
    sclr = 1'b1;
    mode = 2'd1;
    step();
    chk("t5_clr_noen_sq", clk_sq, 0);
    chk("t5_clr_noen_mode", mode_act, 1);
    chk("t5_clr_noen_tick", tick, 0);
    sclr = 1'b0;
    en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("t5_div5_tick", tick, c == 5);
    end
    mode = 2'd3;
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    chk("t6_pre_tick", tick, 1);
    chk("t6_pre_sq", clk_sq, 1);
    chk("t6_pre_mode", mode_act, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_sq", clk_sq, 0);
    chk("t6_rst_sub", sub_tick, 0);
    chk("t6_rst_mode", mode_act, 0);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("t6_tick", tick, c == 3);
    end
    chk("t6_mode", mode_act, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
